// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with PC tag queue, packet FIFO and redirect flush.
// Ports: clk/rst, imem req/addr/ready/rvalid/rdata, i_redirect/_pc, i_stall, o_if_pkt_data/_valid.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic [63:0] o_if_pkt_data,
  output logic        o_if_pkt_valid
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_tag [FIFO_DEPTH];
  logic [PW-1:0] r_tag_wp;
  logic [PW-1:0] r_tag_rp;
  logic [63:0]   r_buf [FIFO_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;

  logic          w_pop;
  logic          w_req;
  logic          w_acc;
  logic          w_rv;
  logic          w_drop;
  logic          w_push;
  logic [CW:0]   w_used;
  logic [CW-1:0] w_disc_nxt;
  logic [1:0]    w_state_nxt;
  logic          w_unused;

  assign w_unused = ^i_redirect_pc[1:0];

  assign w_pop = (r_cnt != '0) && !i_stall;

  // A head leaving this cycle frees its slot for a new request,
  // which keeps one packet per cycle with single-cycle memory.
  assign w_used = {1'b0, r_out} + {1'b0, r_cnt}
                - {{CW{1'b0}}, w_pop};

  assign w_req = (r_state == S_RUN) && !i_redirect
               && (w_used < DEPTH);
  assign w_acc = w_req && i_imem_ready;

  // Responses with nothing outstanding are stray and ignored.
  assign w_rv   = i_imem_rvalid && (r_out != '0);
  assign w_drop = w_rv && (i_redirect || (r_disc != '0));
  assign w_push = w_rv && !w_drop;

  // A response landing in the redirect cycle is dropped now,
  // so it is not counted again for discard.
  always_comb begin
    w_disc_nxt = r_disc;
    if (i_redirect && (r_state != S_FLUSH))
      w_disc_nxt = r_out - CW'(w_rv);
    else if (w_rv && (r_disc != '0))
      w_disc_nxt = r_disc - CW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (i_redirect && (w_disc_nxt != '0))
                 w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_disc_nxt == '0)
                 w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_BOOT;
      r_pc     <= {RESET_PC[31:2], 2'b00};
      r_out    <= '0;
      r_disc   <= '0;
      r_cnt    <= '0;
      r_tag_wp <= '0;
      r_tag_rp <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_disc  <= w_disc_nxt;
      r_out   <= r_out + CW'(w_acc) - CW'(w_rv);
      if (i_redirect)
        r_pc <= {i_redirect_pc[31:2], 2'b00};
      else if (w_acc)
        r_pc <= r_pc + 32'd4;
      if (w_acc)
        r_tag_wp <= r_tag_wp + PW'(1);
      if (w_rv)
        r_tag_rp <= r_tag_rp + PW'(1);
      // Flush wins over a same-cycle pop; that head counts as taken.
      if (i_redirect) begin
        r_cnt <= '0;
        r_wp  <= '0;
        r_rp  <= '0;
      end else begin
        if (w_push)
          r_wp <= r_wp + PW'(1);
        if (w_pop)
          r_rp <= r_rp + PW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc)
      r_tag[r_tag_wp] <= r_pc;
    if (w_push)
      r_buf[r_wp] <= {r_tag[r_tag_rp], i_imem_rdata};
  end

  assign o_imem_req     = w_req;
  assign o_imem_addr    = r_pc;
  assign o_if_pkt_valid = (r_cnt != '0);
  assign o_if_pkt_data  = o_if_pkt_valid ? r_buf[r_rp] : 64'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a packet-stream model.
// Ports: none; drives a fetch_unit instance and a wrap-around instance.
`timescale 1ns/1ps
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready = 1'b1;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        i_stall = 1'b0;
  logic [63:0] o_if_pkt_data;
  logic        o_if_pkt_valid;

  logic        w2_req;
  logic [31:0] w2_addr;
  logic        w2_rvalid = 1'b0;
  logic [31:0] w2_rdata = 32'h0;
  logic [63:0] w2_data;
  logic        w2_valid;
  logic        w2_acc_q = 1'b0;
  logic [31:0] w2_acc_a = 32'h0;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] exp_pc = 32'h0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } rq_t;
  rq_t mq[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_stall(i_stall),
    .o_if_pkt_data(o_if_pkt_data), .o_if_pkt_valid(o_if_pkt_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst(rst),
    .o_imem_req(w2_req), .o_imem_addr(w2_addr),
    .i_imem_ready(1'b1), .i_imem_rvalid(w2_rvalid),
    .i_imem_rdata(w2_rdata),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .i_stall(1'b0),
    .o_if_pkt_data(w2_data), .o_if_pkt_valid(w2_valid)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits for the next valid packet and checks it is the given pc.
  task automatic wait_pkt(input logic [31:0] pc, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_if_pkt_valid) got = 1'b1;
    end
    if (got) chk(nm, o_if_pkt_data, {pc, memf(pc)});
    else begin
      vecs++;
      miss++;
      $display("FAIL %s: timeout, no packet, expected pc %h", nm, pc);
    end
  endtask

  // Main memory: in-order, per-request latency chosen at acceptance.
  always @(negedge clk)
    if (o_imem_req && i_imem_ready)
      mq.push_back('{o_imem_addr, cyc + lat});

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = memf(mq[0].a);
      void'(mq.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0;
    end
  end

  // Wrap instance memory: fixed single-cycle latency.
  always @(negedge clk) begin
    w2_acc_q = w2_req;
    w2_acc_a = w2_addr;
  end

  always @(posedge clk) begin
    #1;
    w2_rvalid = w2_acc_q;
    w2_rdata  = memf(w2_acc_a);
  end

  // Stream model: Decode must see consecutive pcs from the last
  // reset/redirect target, each with its memory word.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", {63'h0, o_imem_req}, 64'h0);
      chk("rst_valid", {63'h0, o_if_pkt_valid}, 64'h0);
      chk("rst_data", o_if_pkt_data, 64'h0);
      exp_pc = 32'h0;
    end else begin
      if (o_imem_req)
        chk("addr_align", {62'h0, o_imem_addr[1:0]}, 64'h0);
      if (i_redirect)
        chk("redir_noreq", {63'h0, o_imem_req}, 64'h0);
      if (o_if_pkt_valid && !i_stall) begin
        chk("stream_pkt", o_if_pkt_data, {exp_pc, memf(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      if (i_redirect)
        exp_pc = {i_redirect_pc[31:2], 2'b00};
    end
  end

  initial begin
    bit got;
    // Streaming and wrap
    do_reset();
    @(negedge clk);
    chk("boot_req", {63'h0, o_imem_req}, 64'h0);
    chk("boot_valid", {63'h0, o_if_pkt_valid}, 64'h0);
    tick(); @(negedge clk);
    chk("c1_req", {63'h0, o_imem_req}, 64'h1);
    chk("c1_addr", {32'h0, o_imem_addr}, 64'h0);
    tick(); @(negedge clk);
    chk("c2_valid", {63'h0, o_if_pkt_valid}, 64'h0);
    tick(); @(negedge clk);
    chk("c3_valid", {63'h0, o_if_pkt_valid}, 64'h1);
    chk("c3_pkt", o_if_pkt_data, {32'h0, 32'h0000_FFFF});
    chk("wrap_pkt0", w2_data, {32'hFFFF_FFFC, 32'hFFFC_0000});
    tick(); @(negedge clk);
    chk("c4_pkt", o_if_pkt_data, {32'h4, 32'h0004_FFFF});
    chk("wrap_pkt1", w2_data, {32'h0, 32'h0000_FFFF});
    for (int i = 0; i < 6; i++) begin
      tick(); @(negedge clk);
      chk("stream_rate", {63'h0, o_if_pkt_valid}, 64'h1);
    end
    tick(); i_imem_ready = 1'b0;
    tick(); tick(); i_imem_ready = 1'b1;
    repeat (4) tick();
    // Misaligned redirect
    i_redirect = 1'b1;
    i_redirect_pc = 32'h203;
    tick(); i_redirect = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (o_imem_req) got = 1'b1;
      else tick();
    end
    chk("mis_req", {63'h0, got}, 64'h1);
    chk("mis_addr", {32'h0, o_imem_addr}, 64'h200);
    wait_pkt(32'h200, "mis_pkt");
    // Backpressure from reset
    tick(); i_stall = 1'b1;
    do_reset();
    repeat (6) tick();
    @(negedge clk);
    chk("bp_req", {63'h0, o_imem_req}, 64'h0);
    chk("bp_valid", {63'h0, o_if_pkt_valid}, 64'h1);
    chk("bp_head", o_if_pkt_data, {32'h0, 32'h0000_FFFF});
    tick(); i_stall = 1'b0;
    @(negedge clk);
    chk("bp_pop", o_if_pkt_data, {32'h0, 32'h0000_FFFF});
    tick(); @(negedge clk);
    chk("bp_next", o_if_pkt_data, {32'h4, 32'h0004_FFFF});
    repeat (8) tick();
    // Redirect with two outstanding
    lat = 3;
    do_reset();
    tick(); tick(); tick();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    tick(); i_redirect = 1'b0;
    @(negedge clk);
    chk("fl_req4", {63'h0, o_imem_req}, 64'h0);
    chk("fl_valid4", {63'h0, o_if_pkt_valid}, 64'h0);
    tick(); @(negedge clk);
    chk("fl_req5", {63'h0, o_imem_req}, 64'h0);
    chk("fl_valid5", {63'h0, o_if_pkt_valid}, 64'h0);
    tick(); @(negedge clk);
    chk("fl_req6", {63'h0, o_imem_req}, 64'h1);
    chk("fl_addr", {32'h0, o_imem_addr}, 64'h100);
    wait_pkt(32'h100, "fl_pkt");
    // Mid-stream reset with a response in flight
    tick(); lat = 1;
    repeat (6) tick();
    i_stall = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (!o_imem_req && o_if_pkt_valid) got = 1'b1;
      else tick();
    end
    chk("mr_full", {63'h0, got}, 64'h1);
    tick(); lat = 3; i_stall = 1'b0;
    @(negedge clk);
    chk("mr_req", {63'h0, o_imem_req}, 64'h1);
    tick(); rst = 1'b1; lat = 1;
    @(negedge clk);
    chk("mr_valid", {63'h0, o_if_pkt_valid}, 64'h0);
    chk("mr_data", o_if_pkt_data, 64'h0);
    tick(); rst = 1'b0;
    wait_pkt(32'h0, "mr_first");
    repeat (6) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
